ldo_pass_sequencer: RTL and testbench

- Closed-loop controller for the 32-device digital LDO pass array.
- Samples the synchronised comparator decision each clock and moves a thermometer-coded pass-transistor enable word.
- Uses a coarse search, then a fine ±1 tracking phase, then detects a limit cycle and freezes the code.
- Sits between the comparator/RS-latch/inverter chain and the pass-transistor bank; provides a registered test-mode override of the enable word.

---
 rtl/ldo_pass_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ldo_pass_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ldo_pass_sequencer.sv
// Closed-loop digital LDO pass-array sequencer: coarse search, fine +/-1 tracking, limit-cycle lock.
// Optional LDO_PASS_ROTATE_EN adds a data-weighted-averaging rotation of the thermometer enable word.
module ldo_pass_sequencer #(
    parameter int N_PASS      = 32,
    parameter int CW          = 6,
    parameter int COARSE_STEP = 4,
    parameter int LC_WINDOW   = 8,
    parameter int UNLOCK_RUN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              comp_in,
    input  logic              test_mode,
    input  logic [N_PASS-1:0] test_code,
    output logic [N_PASS-1:0] pass_code,
    output logic [CW-1:0]     active_count,
    output logic [1:0]        state,
    output logic              locked,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam int LW = $clog2(LC_WINDOW + 1);
    localparam int RW = $clog2(UNLOCK_RUN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        LOCK   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [LW-1:0]     lc_reg, lc_next;
    logic [RW-1:0]     run_reg, run_next;
    logic              last_comp_reg, last_comp_next;
    logic [N_PASS-1:0] pass_code_reg, pass_code_next;
    logic [N_PASS-1:0] therm_next;
    logic [N_PASS-1:0] decoded_next;
    logic              flip;

    // Move the count by amt toward comp direction, clamped to 0..N_PASS.
    function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c, input logic up, input int amt);
        int t;
        t = up ? (int'(c) + amt) : (int'(c) - amt);
        if (t > N_PASS) t = N_PASS;
        if (t < 0)      t = 0;
        return CW'(t);
    endfunction

    assign flip = (comp_in != last_comp_reg);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        lc_next        = lc_reg;
        run_next       = run_reg;
        last_comp_next = comp_in;

        if (test_mode || !en) begin
            state_next = IDLE;
            count_next = '0;
            lc_next    = '0;
            run_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = COARSE;
                end
                COARSE: begin
                    if (flip) begin
                        count_next = sat_step(count_reg, comp_in, 1);
                        state_next = FINE;
                        lc_next    = LW'(1);
                    end else begin
                        count_next = sat_step(count_reg, comp_in, COARSE_STEP);
                    end
                end
                FINE: begin
                    count_next = sat_step(count_reg, comp_in, 1);
                    if (flip) begin
                        if (int'(lc_reg) + 1 >= LC_WINDOW) begin
                            state_next = LOCK;
                            lc_next    = '0;
                        end else begin
                            lc_next = lc_reg + LW'(1);
                        end
                    end else begin
                        lc_next = '0;
                    end
                end
                LOCK: begin
                    if (!flip) begin
                        if (int'(run_reg) + 1 >= UNLOCK_RUN) begin
                            state_next = FINE;
                            count_next = sat_step(count_reg, comp_in, 1);
                            run_next   = '0;
                        end else begin
                            run_next = run_reg + RW'(1);
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Thermometer decode of the next-state count so pass_code lines up with active_count.
    genvar gi;
    generate
        for (gi = 0; gi < N_PASS; gi++) begin : g_therm
            assign therm_next[gi] = (CW'(gi) < count_next);
        end
    endgenerate

`ifdef LDO_PASS_ROTATE_EN
    logic [CW-2:0]       rot_ptr_reg, rot_ptr_next;
    logic [2*N_PASS-1:0] rot_dbl;

    always_comb begin
        int delta;
        delta = (count_next > count_reg) ? int'(count_next) - int'(count_reg)
                                         : int'(count_reg) - int'(count_next);
        if (test_mode || !en || state_reg == IDLE)
            rot_ptr_next = '0;
        else
            rot_ptr_next = (CW-1)'((int'(rot_ptr_reg) + delta) % N_PASS);
        rot_dbl      = {therm_next, therm_next} << rot_ptr_next;
        decoded_next = rot_dbl[2*N_PASS-1:N_PASS];
    end

    always_ff @(posedge clk) begin
        if (rst) rot_ptr_reg <= '0;
        else     rot_ptr_reg <= rot_ptr_next;
    end
`else
    assign decoded_next = therm_next;
`endif

    assign pass_code_next = test_mode ? test_code : decoded_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            lc_reg        <= '0;
            run_reg       <= '0;
            last_comp_reg <= 1'b0;
            pass_code_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            lc_reg        <= lc_next;
            run_reg       <= run_next;
            last_comp_reg <= last_comp_next;
            pass_code_reg <= pass_code_next;
        end
    end

    assign pass_code    = pass_code_reg;
    assign active_count = count_reg;
    assign state        = state_reg;
    assign locked       = (state_reg == LOCK);
    assign sat_hi       = (int'(count_reg) == N_PASS);
    assign sat_lo       = (count_reg == '0) && (state_reg != IDLE);

endmodule

// File: tb/tb_ldo_pass_sequencer.sv
// Directed self-checking bench for ldo_pass_sequencer (default build, no rotation).
module tb_ldo_pass_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        comp_in;
    logic        test_mode;
    logic [31:0] test_code;
    logic [31:0] pass_code;
    logic [5:0]  active_count;
    logic [1:0]  state;
    logic        locked;
    logic        sat_hi;
    logic        sat_lo;

    int compared   = 0;
    int mismatched = 0;

    ldo_pass_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .comp_in      (comp_in),
        .test_mode    (test_mode),
        .test_code    (test_code),
        .pass_code    (pass_code),
        .active_count (active_count),
        .state        (state),
        .locked       (locked),
        .sat_hi       (sat_hi),
        .sat_lo       (sat_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        compared++;
        assert (obs === exp_v)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp_v);
    endtask

    initial begin
        int lock_comp [7] = '{1, 0, 1, 0, 1, 0, 1};
        int lock_cnt  [7] = '{12, 11, 12, 11, 12, 11, 12};

        rst = 1'b1; en = 1'b1; comp_in = 1'b1; test_mode = 1'b0; test_code = '0;
        repeat (3) tick();
        check("rst_pass", 64'(pass_code), 64'h0);
        check("rst_count", 64'(active_count), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_sat_hi", 64'(sat_hi), 64'd0);

        rst = 1'b0;
        tick();
        check("enter_coarse", 64'(state), 64'd1);
        check("coarse_cnt0", 64'(active_count), 64'd0);
        check("sat_lo_zero", 64'(sat_lo), 64'd1);

        for (int i = 1; i <= 8; i++) begin
            tick();
            check("ramp_count", 64'(active_count), 64'(4 * i));
        end
        check("ramp_pass", 64'(pass_code), 64'hFFFF_FFFF);
        check("ramp_sat_hi", 64'(sat_hi), 64'd1);
        tick();
        check("sat_hold_cnt", 64'(active_count), 64'd32);
        check("sat_hold_st", 64'(state), 64'd1);

        en = 1'b0;
        tick();
        check("dis_state", 64'(state), 64'd0);
        check("dis_count", 64'(active_count), 64'd0);

        en = 1'b1; comp_in = 1'b1;
        tick();
        check("re_coarse", 64'(state), 64'd1);
        repeat (3) tick();
        check("at_twelve", 64'(active_count), 64'd12);
        comp_in = 1'b0;
        tick();
        check("fine_state", 64'(state), 64'd2);
        check("fine_count", 64'(active_count), 64'd11);
        check("fine_pass", 64'(pass_code), 64'h0000_07FF);

        // Coarse-to-fine flip is the first of the 8; seven more alternations reach LOCK.
        for (int i = 0; i < 7; i++) begin
            comp_in = lock_comp[i][0];
            tick();
            check("alt_count", 64'(active_count), 64'(lock_cnt[i]));
            check("alt_state", 64'(state), (i == 6) ? 64'd3 : 64'd2);
        end
        check("lock_flag", 64'(locked), 64'd1);
        check("lock_pass", 64'(pass_code), 64'h0000_0FFF);

        for (int i = 0; i < 3; i++) begin
            comp_in = i[0] ? 1'b1 : 1'b0;
            tick();
            check("frozen_cnt", 64'(active_count), 64'd12);
            check("frozen_st", 64'(state), 64'd3);
        end

        comp_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("unlock_st", 64'(state), (i == 4) ? 64'd2 : 64'd3);
            check("unlock_cnt", 64'(active_count), (i == 4) ? 64'd11 : 64'd12);
        end
        check("unlock_lockd", 64'(locked), 64'd0);

        en = 1'b0;
        tick();
        check("off_state", 64'(state), 64'd0);
        check("off_count", 64'(active_count), 64'd0);
        check("off_pass", 64'(pass_code), 64'h0);

        en = 1'b1; test_mode = 1'b1; test_code = 32'hA5A5_A5A5;
        tick();
        check("tm_pass", 64'(pass_code), 64'hA5A5_A5A5);
        check("tm_state", 64'(state), 64'd0);
        check("tm_count", 64'(active_count), 64'd0);

        test_mode = 1'b0; en = 1'b0;
        tick();
        check("tm_exit_pass", 64'(pass_code), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
